cplx_fp_butterfly_mac: RTL and testbench
========================================

Name: cplx_fp_butterfly_mac

Overview:
- Complex single-precision floating-point multiply-accumulate for radix-2 FFT butterflies.
- Takes two complex operands A and B and two complex weights W1 and W2.
- Produces O1 = A + W1*B and O2 = A + W2*B; with W1 = +1, W2 = -1 it is a plain butterfly.
- Sits inside the FFT stage datapath, fed by the stage input muxes; its outputs feed the stage output demuxes.
- One registered pipeline stage.

Parameters:
- none (format fixed: IEEE-754 binary32 per real/imag component).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies the operand set on this cycle.
- a  in  64  complex operand A; [63:32] real, [31:0] imag, each binary32.
- b  in  64  complex operand B, same packing.
- w1  in  64  complex weight for O1, same packing.
- w2  in  64  complex weight for O2, same packing.
- o1  out  64  A + W1*B, same packing, registered.
- o2  out  64  A + W2*B, same packing, registered.
- out_valid  out  1  o1/o2 hold the result of the operand set accepted one cycle earlier.

Behaviour:
- Reset (reset=1 at a rising clk edge): o1=0, o2=0, out_valid=0. Reset dominates in_valid on the same edge.
- Latency is exactly 1 cycle: operands sampled at edge N appear on o1/o2 after edge N.
  - out_valid is in_valid delayed by one cycle.
- When in_valid=0, o1/o2 hold their previous values; out_valid=0.
- Full throughput: a new operand set is accepted every cycle. No backpressure.
- Per output k (W = wk), the operation order is fixed, each step an independent binary32 operation:
  - t1 = Wr*Br; t2 = Wi*Bi; pr = t1 - t2; Or = Ar + pr.
  - t3 = Wr*Bi; t4 = Wi*Br; pi = t3 + t4; Oi = Ai + pi.
- Rounding: round toward zero (truncate) at each step.
- Subnormal inputs are flushed to signed zero before use. Subnormal results are flushed to +0.
- Exact zero results (including cancellation such as 1.0 - 1.0) are +0 (0x00000000).
- Overflow: the result is signed infinity (0x7F800000 / 0xFF800000).
- Any operand with exponent 255 (Inf or NaN) entering a step makes that step's result the canonical qNaN 0x7FC00000, which then propagates.
- Multiplication by exactly ±1.0 or ±0 must produce the exact mathematical result; no rounding error is introduced.
- Implementation: combinational fp_mul/fp_add helper logic feeding the output register. Helpers may be shared submodules.

Optional Feature:
- Macro: MAC_RNE_EN.
- Defined: every multiply/add step uses round-to-nearest, ties-to-even; all other rules are unchanged.
- Undefined: truncation as specified above.
- Latency is 1 cycle in both builds.

Test Plan:
- Reset: hold reset=1 for 2 cycles with in_valid=1 and random operands -> o1=o2=0, out_valid=0. Release -> the next accepted set appears one cycle later.
- Real butterfly: a=0x3F800000_00000000 (1.0), b=0x40000000_00000000 (2.0), w1=0x3F800000_00000000, w2=0xBF800000_00000000 -> o1=0x40400000_00000000 (3.0), o2=0xBF800000_00000000 (-1.0), out_valid=1 one cycle later.
- Complex rotate: a=0, b=0x3F800000_3F800000 (1+j), w1=0x00000000_3F800000 (j) -> o1=0xBF800000_3F800000 (-1+j).
- Cancellation: a=1.0, b=1.0, w2=-1.0 -> o2=0x00000000_00000000 (+0, not -0).
- Special values: b real = 0x7F800000 (Inf) -> affected components are 0x7FC00000. b real = 0x00000001 (subnormal) with a=0 -> o1 real = 0x00000000.
- Streaming: 8 back-to-back in_valid cycles with varying b, then in_valid=0 for 2 cycles -> 8 consecutive out_valid cycles with matching results in order, then outputs hold the last value with out_valid=0.

Source files
------------

// File: rtl/cplx_fp_butterfly_mac.sv
// Complex binary32 multiply-accumulate O1 = A + W1*B, O2 = A + W2*B with one registered stage.
// Define MAC_RNE_EN for round-to-nearest-even at every step; default build truncates.
module cplx_fp_butterfly_mac (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [63:0] w1,
    input  logic [63:0] w2,
    output logic [63:0] o1,
    output logic [63:0] o2,
    output logic        out_valid
);

    localparam logic [31:0] QNAN = 32'h7FC00000;

`ifdef MAC_RNE_EN
    localparam logic RNE = 1'b1;
`else
    localparam logic RNE = 1'b0;
`endif

    logic [63:0] o1_p0, o2_p0;
    logic [63:0] o1_p1, o2_p1;
    logic        vld_p1;

    // Round a normalised 24-bit significand, then apply overflow-to-Inf and underflow-to-+0.
    function automatic logic [31:0] fp_round(
        input logic               sgn,
        input logic signed [10:0] exp_in,
        input logic [23:0]        man,
        input logic               rnd,
        input logic               stk
    );
        logic signed [10:0] e;
        logic [24:0]        m;
        logic               inc;
        e   = exp_in;
        inc = RNE & rnd & (stk | man[0]);
        m   = {1'b0, man} + {24'd0, inc};
        if (m[24]) begin
            m = m >> 1;
            e = e + 11'sd1;
        end
        if (e >= 11'sd255) begin
            fp_round = {sgn, 8'hFF, 23'd0};
        end else if (e <= 11'sd0) begin
            fp_round = 32'd0;
        end else begin
            fp_round = {sgn, e[7:0], m[22:0]};
        end
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic [47:0]        prod;
        logic signed [10:0] e;
        logic               sgn;
        sgn  = x[31] ^ y[31];
        prod = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
        e    = $signed({3'b000, x[30:23]}) + $signed({3'b000, y[30:23]}) - 11'sd127;
        if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
            fp_mul = QNAN;
        end else if (x[30:23] == 8'h00 || y[30:23] == 8'h00) begin
            // Subnormals are flushed, so any zero operand gives an exact +0.
            fp_mul = 32'd0;
        end else if (prod[47]) begin
            fp_mul = fp_round(sgn, e + 11'sd1, prod[47:24], prod[23], |prod[22:0]);
        end else begin
            fp_mul = fp_round(sgn, e, prod[46:23], prod[22], |prod[21:0]);
        end
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0]        big, sml;
        logic [49:0]        mb, ms, shifted;
        logic [50:0]        r, n;
        logic [7:0]         d;
        logic [5:0]         p;
        logic signed [10:0] e;
        fp_add = 32'd0;
        if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
            fp_add = QNAN;
        end else if (x[30:23] == 8'h00 && y[30:23] == 8'h00) begin
            fp_add = 32'd0;
        end else if (x[30:23] == 8'h00) begin
            fp_add = y;
        end else if (y[30:23] == 8'h00) begin
            fp_add = x;
        end else begin
            if (x[30:0] >= y[30:0]) begin
                big = x;
                sml = y;
            end else begin
                big = y;
                sml = x;
            end
            d  = big[30:23] - sml[30:23];
            mb = {1'b1, big[22:0], 26'd0};
            ms = {1'b1, sml[22:0], 26'd0};
            // Bits shifted past the wide field collapse into a sticky LSB.
            if (d >= 8'd50) begin
                shifted = 50'd1;
            end else begin
                shifted    = ms >> d;
                shifted[0] = shifted[0] | (|(ms & ~({50{1'b1}} << d)));
            end
            if (big[31] == sml[31]) begin
                r = {1'b0, mb} + {1'b0, shifted};
            end else begin
                r = {1'b0, mb} - {1'b0, shifted};
            end
            if (r != 51'd0) begin
                p = 6'd0;
                for (int i = 0; i < 51; i++) begin
                    if (r[i]) p = i[5:0];
                end
                n = r << (6'd50 - p);
                e = $signed({3'b000, big[30:23]}) + $signed({5'b00000, p}) - 11'sd49;
                fp_add = fp_round(big[31], e, n[50:27], n[26], |n[25:0]);
            end
        end
    endfunction

    function automatic logic [31:0] fp_sub(input logic [31:0] x, input logic [31:0] y);
        fp_sub = fp_add(x, {~y[31], y[30:0]});
    endfunction

    function automatic logic [63:0] cmac(
        input logic [63:0] av,
        input logic [63:0] bv,
        input logic [63:0] wv
    );
        logic [31:0] t1, t2, t3, t4, pr, pim;
        t1   = fp_mul(wv[63:32], bv[63:32]);
        t2   = fp_mul(wv[31:0],  bv[31:0]);
        pr   = fp_sub(t1, t2);
        t3   = fp_mul(wv[63:32], bv[31:0]);
        t4   = fp_mul(wv[31:0],  bv[63:32]);
        pim  = fp_add(t3, t4);
        cmac = {fp_add(av[63:32], pr), fp_add(av[31:0], pim)};
    endfunction

    // Stage p0: combinational complex MAC for both weights
    always_comb begin
        o1_p0 = cmac(a, b, w1);
        o2_p0 = cmac(a, b, w2);
    end

    // Stage p1: output register; results hold while no operand set is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            o1_p1  <= 64'd0;
            o2_p1  <= 64'd0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                o1_p1 <= o1_p0;
                o2_p1 <= o2_p0;
            end
        end
    end

    assign o1        = o1_p1;
    assign o2        = o2_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_cplx_fp_butterfly_mac.sv
// Scoreboard bench for cplx_fp_butterfly_mac: expected results queued at drive time.
module tb_cplx_fp_butterfly_mac;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] a, b, w1, w2;
    logic [63:0] o1, o2;
    logic        out_valid;

    typedef struct packed {
        logic [63:0] e1;
        logic [63:0] e2;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [63:0] C_ONE  = 64'h3F800000_00000000;
    localparam logic [63:0] C_NEG1 = 64'hBF800000_00000000;
    localparam logic [63:0] C_NAN2 = 64'h7FC00000_7FC00000;

    cplx_fp_butterfly_mac dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .w1       (w1),
        .w2       (w2),
        .o1       (o1),
        .o2       (o2),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f32_of_int(input int v);
        int          mag;
        int          msb;
        logic [31:0] m;
        if (v == 0) return 32'd0;
        mag = (v < 0) ? -v : v;
        msb = 0;
        for (int i = 0; i < 24; i++) if (mag[i]) msb = i;
        m = mag;
        m = m << (23 - msb);
        return {(v < 0), 8'(127 + msb), m[22:0]};
    endfunction

    function automatic logic [63:0] cx(input int re, input int im);
        return {f32_of_int(re), f32_of_int(im)};
    endfunction

    function automatic logic [63:0] cmac_int(input int ar, input int ai, input int wr,
                                             input int wi, input int br, input int bi);
        return cx(ar + wr * br - wi * bi, ai + wr * bi + wi * br);
    endfunction

    task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic [63:0] w1v,
                        input logic [63:0] w2v, input logic [63:0] e1, input logic [63:0] e2);
        exp_t ev;
        a = av; b = bv; w1 = w1v; w2 = w2v;
        in_valid = 1'b1;
        ev.e1 = e1;
        ev.e2 = e2;
        sb.push_back(ev);
    endtask

    task automatic test_reset();
        exp_t ev;
        reset = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            w1 = {$urandom, $urandom};
            w2 = {$urandom, $urandom};
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
            total++; if (o1 !== 64'd0) begin bad++; $display("FAIL reset_o1 got=%h want=0", o1); end
            total++; if (o2 !== 64'd0) begin bad++; $display("FAIL reset_o2 got=%h want=0", o2); end
        end
        reset = 1'b0;
        send(cx(5, 1), cx(2, 3), C_ONE, C_NEG1, cx(7, 4), cx(3, -2));
        @(negedge clk);
        in_valid = 1'b0;
        ev = sb.pop_front();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL release_valid got=%b want=1", out_valid); end
        total++; if (o1 !== ev.e1) begin bad++; $display("FAIL release_o1 got=%h want=%h", o1, ev.e1); end
        total++; if (o2 !== ev.e2) begin bad++; $display("FAIL release_o2 got=%h want=%h", o2, ev.e2); end
    endtask

    task automatic test_vectors();
        exp_t        ev;
        logic [63:0] va[7], vb[7], vw1[7], vw2[7], x1[7], x2[7];
        // butterfly, complex rotate, cancellation, Inf, subnormal, overflow, product tie
        va[0] = C_ONE;  vb[0] = 64'h40000000_00000000; vw1[0] = C_ONE;  vw2[0] = C_NEG1;
        x1[0] = 64'h40400000_00000000; x2[0] = 64'hBF800000_00000000;
        va[1] = 64'd0;  vb[1] = 64'h3F800000_3F800000; vw1[1] = 64'h00000000_3F800000;
        vw2[1] = 64'h00000000_BF800000;
        x1[1] = 64'hBF800000_3F800000; x2[1] = 64'h3F800000_BF800000;
        va[2] = C_ONE;  vb[2] = C_ONE; vw1[2] = C_ONE; vw2[2] = C_NEG1;
        x1[2] = 64'h40000000_00000000; x2[2] = 64'd0;
        va[3] = 64'd0;  vb[3] = 64'h7F800000_00000000; vw1[3] = C_ONE; vw2[3] = C_NEG1;
        x1[3] = C_NAN2; x2[3] = C_NAN2;
        va[4] = 64'd0;  vb[4] = 64'h00000001_00000000; vw1[4] = C_ONE; vw2[4] = C_NEG1;
        x1[4] = 64'd0;  x2[4] = 64'd0;
        va[5] = 64'd0;  vb[5] = 64'h7F000000_00000000; vw1[5] = 64'h40000000_00000000;
        vw2[5] = 64'hC0000000_00000000;
        x1[5] = 64'h7FC00000_00000000; x2[5] = 64'h7FC00000_00000000;
        va[6] = 64'd0;  vb[6] = 64'h3FC00000_00000000; vw1[6] = 64'h3F800001_00000000;
        vw2[6] = C_NEG1;
`ifdef MAC_RNE_EN
        x1[6] = 64'h3FC00002_00000000;
`else
        x1[6] = 64'h3FC00001_00000000;
`endif
        x2[6] = 64'hBFC00000_00000000;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            send(va[i], vb[i], vw1[i], vw2[i], x1[i], x2[i]);
            @(negedge clk);
            in_valid = 1'b0;
            ev = sb.pop_front();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL vec%0d_valid got=%b want=1", i, out_valid); end
            total++; if (o1 !== ev.e1) begin bad++; $display("FAIL vec%0d_o1 got=%h want=%h", i, o1, ev.e1); end
            total++; if (o2 !== ev.e2) begin bad++; $display("FAIL vec%0d_o2 got=%h want=%h", i, o2, ev.e2); end
        end
    endtask

    task automatic test_add_rounding();
        exp_t ev;
        @(negedge clk);
`ifdef MAC_RNE_EN
        send(C_ONE, 64'h3F7FFFFF_00000000, C_ONE, 64'd0, 64'h40000000_00000000, C_ONE);
`else
        send(C_ONE, 64'h3F7FFFFF_00000000, C_ONE, 64'd0, 64'h3FFFFFFF_00000000, C_ONE);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        ev = sb.pop_front();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addrnd_valid got=%b want=1", out_valid); end
        total++; if (o1 !== ev.e1) begin bad++; $display("FAIL addrnd_o1 got=%h want=%h", o1, ev.e1); end
        total++; if (o2 !== ev.e2) begin bad++; $display("FAIL addrnd_o2 got=%h want=%h", o2, ev.e2); end
    endtask

    task automatic test_back_to_back();
        int          br[8] = '{2, -3, 5, 0, 7, -1, 4, 6};
        int          bi[8] = '{1, 4, -2, 3, 0, -5, 2, -6};
        exp_t        ev;
        logic [63:0] last1, last2;
        last1 = 64'd0;
        last2 = 64'd0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (sb.size() == 0) begin
                    bad++; total++;
                    $display("FAIL stream%0d_queue got=empty want=entry", i - 1);
                end else begin
                    ev = sb.pop_front();
                    last1 = ev.e1;
                    last2 = ev.e2;
                    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream%0d_valid got=%b want=1", i - 1, out_valid); end
                    total++; if (o1 !== ev.e1) begin bad++; $display("FAIL stream%0d_o1 got=%h want=%h", i - 1, o1, ev.e1); end
                    total++; if (o2 !== ev.e2) begin bad++; $display("FAIL stream%0d_o2 got=%h want=%h", i - 1, o2, ev.e2); end
                end
            end
            if (i < 8) begin
                send(cx(3, -2), cx(br[i], bi[i]), cx(2, 1), cx(-1, 0),
                     cmac_int(3, -2, 2, 1, br[i], bi[i]), cmac_int(3, -2, -1, 0, br[i], bi[i]));
            end else begin
                in_valid = 1'b0;
                a = cx(100, 100);
                b = cx(9, 9);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold%0d_valid got=%b want=0", i, out_valid); end
            total++; if (o1 !== last1) begin bad++; $display("FAIL hold%0d_o1 got=%h want=%h", i, o1, last1); end
            total++; if (o2 !== last2) begin bad++; $display("FAIL hold%0d_o2 got=%h want=%h", i, o2, last2); end
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        a = 64'd0; b = 64'd0; w1 = 64'd0; w2 = 64'd0;
        test_reset();
        test_vectors();
        test_add_rounding();
        test_back_to_back();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
